// File: rtl/tdes_cbc_ctrl_if.sv
// Host and cipher-core handshake bundle for tdes_cbc_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface tdes_cbc_ctrl_if;
    logic        mode_i;
    logic [0:63] iv_i;
    logic        iv_load_i;
    logic [0:63] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [0:63] data_o;
    logic        valid_o;
    logic        core_mode_o;
    logic [0:63] core_data_o;
    logic        core_valid_o;
    logic        core_ready_i;
    logic [0:63] core_data_i;
    logic        core_valid_i;

    modport slave (
        input  mode_i, iv_i, iv_load_i, data_i, valid_i,
        input  core_ready_i, core_data_i, core_valid_i,
        output ready_o, data_o, valid_o,
        output core_mode_o, core_data_o, core_valid_o
    );

    modport master (
        output mode_i, iv_i, iv_load_i, data_i, valid_i,
        output core_ready_i, core_data_i, core_valid_i,
        input  ready_o, data_o, valid_o,
        input  core_mode_o, core_data_o, core_valid_o
    );
endinterface

// File: rtl/tdes_cbc_ctrl.sv
// CBC chaining controller wrapped around an external TDES block cipher core.
// Define CBC_DECRYPT_EN to add the decrypt path; otherwise every block is encrypted.
//
// state | meaning
// IDLE  | ready for iv load or a new block
// ISSUE | block presented to the core, waiting for core_ready_i
// WAIT  | waiting for the core result
// OUT   | result on data_o, valid_o pulse
module tdes_cbc_ctrl (
    input  logic            clk_i,
    input  logic            reset_i,
    tdes_cbc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic        accept, core_done;
    logic        mode_q;
    logic [0:63] chain_q, core_data_q, data_q;
    logic [0:63] iv_sel, core_in, result, chain_nxt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        core_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_i && ready_q) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (bus.core_ready_i) state_d = WAIT;
            WAIT: begin
                if (bus.core_valid_i) begin
                    core_done = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A coincident iv load must already apply to the block being accepted.
    assign iv_sel = bus.iv_load_i ? bus.iv_i : chain_q;

`ifdef CBC_DECRYPT_EN
    logic [0:63] capt_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mode_q <= 1'b0;
            capt_q <= '0;
        end else if (accept) begin
            mode_q <= bus.mode_i;
            capt_q <= bus.data_i;
        end
    end

    always_comb begin
        core_in   = bus.mode_i ? bus.data_i : (bus.data_i ^ iv_sel);
        result    = mode_q ? (bus.core_data_i ^ chain_q) : bus.core_data_i;
        chain_nxt = mode_q ? capt_q : bus.core_data_i;
    end
`else
    assign mode_q    = 1'b0;
    assign core_in   = bus.data_i ^ iv_sel;
    assign result    = bus.core_data_i;
    assign chain_nxt = bus.core_data_i;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ready_q     <= 1'b0;
            chain_q     <= '0;
            core_data_q <= '0;
            data_q      <= '0;
        end else begin
            ready_q <= (state_d == IDLE);
            if (state_q == IDLE && bus.iv_load_i) chain_q <= bus.iv_i;
            if (accept) core_data_q <= core_in;
            if (core_done) begin
                data_q  <= result;
                chain_q <= chain_nxt;
            end
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.valid_o      = (state_q == OUT);
    assign bus.data_o       = data_q;
    assign bus.core_valid_o = (state_q == ISSUE);
    assign bus.core_data_o  = core_data_q;
    assign bus.core_mode_o  = mode_q;
endmodule

// File: tb/tb_tdes_cbc_ctrl.sv
// Scoreboard bench for tdes_cbc_ctrl; the cipher core is modelled as XOR with K, latency 3.
module tb_tdes_cbc_ctrl;
    localparam logic [63:0] K = 64'h0123456789ABCDEF;
`ifdef CBC_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk = ~clk;

    tdes_cbc_ctrl_if bus();
    tdes_cbc_ctrl dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] core_exp_q[$];
    bit          core_mode_q[$];
    logic [63:0] chain_m = '0;

    int          core_cnt  = 0;
    logic [63:0] core_buf  = '0;
    int          xfer_cnt  = 0;
    int          ready_mode = 0;
    bit          stray_req = 1'b0;
    bit          prev_valid = 1'b0;
    logic [63:0] last_out  = '0;
    logic [63:0] last_core = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cipher core model plus core-side scoreboard.
    always @(negedge clk) begin
        bus.core_valid_i = 1'b0;
        if (!reset_i) core_cnt = 0;
        else begin
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.core_valid_i = 1'b1;
                    bus.core_data_i  = core_buf ^ K;
                end
            end
            if (stray_req) begin
                bus.core_valid_i = 1'b1;
                bus.core_data_i  = {$urandom, $urandom};
                stray_req = 1'b0;
            end
        end
        case (ready_mode)
            0:       bus.core_ready_i = 1'b1;
            1:       bus.core_ready_i = 1'($urandom_range(0, 1));
            default: bus.core_ready_i = 1'b0;
        endcase
        if (reset_i && bus.core_valid_o && bus.core_ready_i) begin
            core_buf  = bus.core_data_o;
            last_core = bus.core_data_o;
            core_cnt  = 3;
            xfer_cnt++;
            if (core_exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL core_unexpected: got transfer %h expected none", bus.core_data_o);
            end else begin
                check("core_data_o", bus.core_data_o, core_exp_q.pop_front());
                check("core_mode_o", 64'(bus.core_mode_o), 64'(core_mode_q.pop_front()));
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (reset_i) begin
            if (bus.valid_o) begin
                last_out = bus.data_o;
                check("valid_o_pulse", 64'(prev_valid), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL valid_unexpected: got data_o %h expected no valid_o", bus.data_o);
                end else
                    check("data_o", bus.data_o, exp_q.pop_front());
            end
            prev_valid = bus.valid_o;
        end else
            prev_valid = 1'b0;
    end

    task automatic wait_ready();
        int t = 0;
        while (!bus.ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: got ready_o 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic load_iv(input logic [63:0] iv);
        wait_ready();
        chain_m       = iv;
        bus.iv_i      = iv;
        bus.iv_load_i = 1'b1;
        @(negedge clk);
        bus.iv_load_i = 1'b0;
    endtask

    task automatic send_block(input bit mode, input logic [63:0] d, input bit ld,
                              input logic [63:0] iv, input bit noise);
        bit m;
        logic [63:0] cin, res;
        wait_ready();
        m = DEC_EN ? mode : 1'b0;
        if (ld) chain_m = iv;
        if (m) begin
            cin     = d;
            res     = (d ^ K) ^ chain_m;
            chain_m = d;
        end else begin
            cin     = d ^ chain_m;
            res     = cin ^ K;
            chain_m = res;
        end
        core_exp_q.push_back(cin);
        core_mode_q.push_back(m);
        exp_q.push_back(res);
        bus.mode_i    = mode;
        bus.data_i    = d;
        bus.iv_i      = iv;
        bus.iv_load_i = ld;
        bus.valid_i   = 1'b1;
        @(negedge clk);
        if (noise) begin
            // Block is in flight: these must all be ignored.
            bus.mode_i    = 1'($urandom_range(0, 1));
            bus.data_i    = {$urandom, $urandom};
            bus.iv_i      = {$urandom, $urandom};
            bus.iv_load_i = 1'b1;
            bus.valid_i   = 1'b1;
            @(negedge clk);
        end
        bus.valid_i   = 1'b0;
        bus.iv_load_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, exp_core;
        int x0, t;
        bus.mode_i = 1'b0; bus.iv_i = '0; bus.iv_load_i = 1'b0;
        bus.data_i = '0;   bus.valid_i = 1'b0;
        bus.core_ready_i = 1'b1; bus.core_data_i = '0; bus.core_valid_i = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready_o",      64'(bus.ready_o), 64'd0);
        check("rst_valid_o",      64'(bus.valid_o), 64'd0);
        check("rst_core_valid_o", 64'(bus.core_valid_o), 64'd0);
        check("rst_core_mode_o",  64'(bus.core_mode_o), 64'd0);
        check("rst_data_o",       bus.data_o, 64'd0);
        check("rst_core_data_o",  bus.core_data_o, 64'd0);
        reset_i = 1'b1;
        #1 check("ready_before_edge", 64'(bus.ready_o), 64'd0);
        @(posedge clk); #1;
        check("ready_after_edge", 64'(bus.ready_o), 64'd1);
        @(negedge clk);

        load_iv(64'hFFFFFFFFFFFFFFFF);
        send_block(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        wait_ready();
        check("enc1_core", last_core, 64'hFFFFFFFFFFFFFFFF);
        check("enc1_out",  last_out,  64'hFEDCBA9876543210);
        send_block(1'b0, 64'hFEDCBA9876543210, 1'b0, 64'h0, 1'b0);
        wait_ready();
        check("enc2_core", last_core, 64'h0);
        check("enc2_out",  last_out,  64'h0123456789ABCDEF);

`ifdef CBC_DECRYPT_EN
        load_iv(64'hFFFFFFFFFFFFFFFF);
        send_block(1'b1, 64'hFEDCBA9876543210, 1'b0, 64'h0, 1'b0);
        wait_ready();
        check("dec1_out", last_out, 64'h0);
        send_block(1'b1, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1'b0);
        wait_ready();
        check("dec2_out", last_out, 64'hFEDCBA9876543210);
`endif

        send_block(1'b0, 64'h0, 1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b0);
        wait_ready();
        check("ivload_coincide_core", last_core, 64'hAAAAAAAAAAAAAAAA);

        // Core stall in ISSUE.
        ready_mode = 2;
        x0 = xfer_cnt;
        d  = {$urandom, $urandom};
        send_block(1'b0, d, 1'b0, 64'h0, 1'b0);
        exp_core = core_exp_q[0];
        for (int i = 0; i < 5; i++) begin
            check("stall_core_valid", 64'(bus.core_valid_o), 64'd1);
            check("stall_core_data",  bus.core_data_o, exp_core);
            @(negedge clk);
        end
        ready_mode = 0;
        wait_ready();
        check("stall_xfer_count", 64'(xfer_cnt - x0), 64'd1);

        // Reset while WAIT, then a stray core result.
        x0 = xfer_cnt;
        send_block(1'b0, {$urandom, $urandom}, 1'b0, 64'h0, 1'b0);
        t = 0;
        while (xfer_cnt == x0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reset_test_xfer", 64'(xfer_cnt - x0), 64'd1);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("midrst_ready_o",      64'(bus.ready_o), 64'd0);
        check("midrst_core_valid_o", 64'(bus.core_valid_o), 64'd0);
        check("midrst_data_o",       bus.data_o, 64'd0);
        check("midrst_core_data_o",  bus.core_data_o, 64'd0);
        exp_q.delete();
        core_exp_q.delete();
        core_mode_q.delete();
        chain_m = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        #1 check("midrst_ready_released", 64'(bus.ready_o), 64'd0);
        @(posedge clk); #1;
        check("midrst_ready_edge", 64'(bus.ready_o), 64'd1);
        @(negedge clk);
        stray_req = 1'b1;
        repeat (6) @(negedge clk);
        check("stray_ready_o", 64'(bus.ready_o), 64'd1);
        d = {$urandom, $urandom};
        send_block(1'b0, d, 1'b0, 64'h0, 1'b0);
        wait_ready();
        check("chain_cleared_core", last_core, d);

        // Randomised traffic with core stalls, in-flight noise and iv loads.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) load_iv({$urandom, $urandom});
            send_block(1'($urandom_range(0, 1)), {$urandom, $urandom},
                       ($urandom_range(0, 3) == 0), {$urandom, $urandom},
                       ($urandom_range(0, 2) == 0));
        end
        ready_mode = 0;
        wait_ready();
        repeat (3) @(negedge clk);
        check("exp_q_drained",      64'(exp_q.size()), 64'd0);
        check("core_exp_q_drained", 64'(core_exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
